// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and helpers for the 7-segment scan sequencer
package seg7_pkg;

    localparam int DIGITS = 4;
    localparam int PTR_W  = $clog2(DIGITS);

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    typedef logic [3:0] digit_code_t;

    // Active-low anode pattern with only the indexed digit pulled low.
    function automatic logic [DIGITS-1:0] sel_onehot_low(input logic [PTR_W-1:0] idx);
        sel_onehot_low = ~(DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, stability debouncer and press pulse for an active-low button
module btn_debounce #(
    parameter int DEB_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic fall
);

    localparam int CW = (DEB_CYC > 0) ? $clog2(DEB_CYC + 1) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DEB_CYC - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          fall_q;
    logic          differ;
    logic          flip;

    assign differ = (sync_q != level_q);
    assign flip   = differ && (cnt_q == C_LAST);
    assign fall   = fall_q;

    // Released is the safe resting level, so the whole chain resets high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            meta_q <= btn_n;
            sync_q <= meta_q;
            fall_q <= flip && !sync_q;
            if (!differ) begin
                cnt_q <= '0;
            end else if (flip) begin
                level_q <= sync_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - four-digit multiplexed 7-segment scan sequencer with switch load
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int DEB_CYC   = 500000,
    parameter int LZ_BLANK  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        ch,
    input  logic              btn_load_n,
    output digit_code_t       dig_code,
    output logic [DIGITS-1:0] dig_sel_n,
    output logic              dig_blank,
    output logic              dp_n,
    output logic              load_ack
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
    localparam logic [0:0]    ST_BLANK = BLANK;
    localparam logic [0:0]    ST_DRIVE = DRIVE;

    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_next;
    logic             wrap;
    logic [PTR_W-1:0] ptr_q;
    logic [0:0]       state_q;
    logic [0:0]       state_next;
    logic [7:0]       ch_meta_q;
    logic [7:0]       ch_sync_q;
    logic [15:0]      digit_q;
    logic             load_fall;
    logic             load_ack_q;
    logic             lz3;
    logic             lz2;
    logic             lz1;
    logic             suppress;
    logic             show;

    btn_debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_load_btn (
        .clk  (clk),
        .rst_n(rst_n),
        .btn_n(btn_load_n),
        .fall (load_fall)
    );

    assign wrap = (presc_q == P_LAST);

    // State follows the count it will sit beside, so BLANK/DRIVE stay aligned with the prescaler.
    always_comb begin
        presc_next = wrap ? '0 : presc_q + 1'b1;
        state_next = (presc_next >= P_BLANK) ? ST_DRIVE : ST_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            ptr_q      <= '0;
            state_q    <= ST_BLANK;
            ch_meta_q  <= '0;
            ch_sync_q  <= '0;
            digit_q    <= '0;
            load_ack_q <= 1'b0;
        end else begin
            presc_q    <= presc_next;
            state_q    <= state_next;
            ch_meta_q  <= ch;
            ch_sync_q  <= ch_meta_q;
            load_ack_q <= load_fall;
            if (wrap) begin
                ptr_q <= ptr_q + 1'b1;
            end
            if (load_fall) begin
                digit_q <= {digit_q[7:0], ch_sync_q};
            end
        end
    end

    // A digit is a leading zero when it and everything above it are zero.
    assign lz3 = (digit_q[15:12] == 4'h0);
    assign lz2 = lz3 && (digit_q[11:8] == 4'h0);
    assign lz1 = lz2 && (digit_q[7:4] == 4'h0);

    always_comb begin
        suppress = 1'b0;
        if (LZ_BLANK != 0) begin
            case (ptr_q)
                2'd1:    suppress = lz1;
                2'd2:    suppress = lz2;
                2'd3:    suppress = lz3;
                default: suppress = 1'b0;
            endcase
        end
    end

    assign show      = (state_q == ST_DRIVE) && !suppress;
    assign dig_code  = digit_q[{ptr_q, 2'b00} +: 4];
    assign dig_sel_n = show ? sel_onehot_low(ptr_q) : {DIGITS{1'b1}};
    assign dig_blank = !show;
    assign dp_n      = !(show && (ptr_q == 2'd2));
    assign load_ack  = load_ack_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - randomized self-checking bench for seg7_scan_ctrl against a timeline model
module tb_seg7_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ch;
    logic       btn_load_n;

    logic [3:0] code_a, sel_a, code_b, sel_b;
    logic       blank_a, dp_a, ack_a, blank_b, dp_b, ack_b;

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .DEB_CYC(DC), .LZ_BLANK(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ch(ch), .btn_load_n(btn_load_n),
        .dig_code(code_a), .dig_sel_n(sel_a), .dig_blank(blank_a), .dp_n(dp_a), .load_ack(ack_a)
    );

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .DEB_CYC(DC), .LZ_BLANK(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ch(ch), .btn_load_n(btn_load_n),
        .dig_code(code_b), .dig_sel_n(sel_b), .dig_blank(blank_b), .dp_n(dp_b), .load_ack(ack_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;

    // Model: cycles since reset release, register contents, and sampled input history.
    int          k_m;
    logic [15:0] reg_m;
    logic        deb_m;
    logic        pulse_m;
    logic        ack_m;
    logic        bh [0:7];
    logic [7:0]  chh [0:7];

    function automatic logic [9:0] exp_scan(input int k, input logic [15:0] r, input bit lz);
        int         cnt = k % SD;
        int         ptr = (k / SD) % 4;
        logic [3:0] d = 4'((r >> (4 * ptr)) & 16'h000F);
        bit         supp = lz && (ptr != 0) && ((r >> (4 * ptr)) == 16'h0000);
        bit         drv = (cnt >= BC) && !supp;
        logic [3:0] sel = drv ? ~(4'b0001 << ptr) : 4'hF;
        return {d, sel, !drv, !(drv && ptr == 2)};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (t=%0t k=%0d)", tag, obs, exp, $time, k_m);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k_m = 0;
        reg_m = 16'h0000;
        deb_m = 1'b1;
        pulse_m = 1'b0;
        ack_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bh[i] = 1'b1;
            chh[i] = 8'h00;
        end
    endtask

    task automatic model_edge();
        logic flip;
        logic new_ack;
        if (!rst_n) begin
            model_reset();
        end else begin
            new_ack = pulse_m;
            if (pulse_m) reg_m = {reg_m[7:0], chh[1]};
            flip = 1'b1;
            for (int i = 1; i <= DC; i++) if (bh[i] == deb_m) flip = 1'b0;
            pulse_m = flip && deb_m;
            if (flip) deb_m = ~deb_m;
            ack_m = new_ack;
            for (int i = 7; i > 0; i--) begin
                bh[i] = bh[i-1];
                chh[i] = chh[i-1];
            end
            bh[0] = btn_load_n;
            chh[0] = ch;
            k_m++;
        end
    endtask

    task automatic check_all();
        logic [9:0] ea;
        logic [9:0] eb;
        ea = exp_scan(k_m, reg_m, 1'b1);
        eb = exp_scan(k_m, reg_m, 1'b0);
        chk("a_code", code_a, ea[9:6]);
        chk("a_sel", sel_a, ea[5:2]);
        chk("a_blank", {3'b000, blank_a}, {3'b000, ea[1]});
        chk("a_dp", {3'b000, dp_a}, {3'b000, ea[0]});
        chk("a_ack", {3'b000, ack_a}, {3'b000, ack_m});
        chk("b_code", code_b, eb[9:6]);
        chk("b_sel", sel_b, eb[5:2]);
        chk("b_blank", {3'b000, blank_b}, {3'b000, eb[1]});
        chk("b_dp", {3'b000, dp_b}, {3'b000, eb[0]});
        chk("b_ack", {3'b000, ack_b}, {3'b000, ack_m});
        if (ack_a === 1'b1) ack_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic chk_reset_now(input string tag);
        chk({tag, "_sel"}, sel_a, 4'hF);
        chk({tag, "_code"}, code_a, 4'h0);
        chk({tag, "_blank"}, {3'b000, blank_a}, 4'h1);
        chk({tag, "_dp"}, {3'b000, dp_a}, 4'h1);
        chk({tag, "_ack"}, {3'b000, ack_a}, 4'h0);
    endtask

    task automatic press(input logic [7:0] v, input int hold, output int lat);
        ch = v;
        repeat (6) tick();
        btn_load_n = 1'b0;
        lat = -1;
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (ack_a === 1'b1 && lat < 0) lat = i;
        end
        btn_load_n = 1'b1;
        repeat (15) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        int a0;
        int cnt;
        int n;

        rst_n = 1'b1;
        btn_load_n = 1'b1;
        ch = 8'h00;
        model_reset();
        #2 rst_n = 1'b0;
        #1 chk_reset_now("por");
        repeat (2) tick();
        rst_n = 1'b1;

        // Idle after reset: only digit 0 is ever driven.
        cnt = 0;
        repeat (32) begin
            tick();
            if (sel_a === 4'b1110) cnt++;
        end
        chk_int("idle_drive_cycles", cnt, 6);

        a0 = ack_cnt;
        press(8'hA5, 10, lat);
        chk_int("a5_latency", lat, 7);
        chk_int("a5_acks", ack_cnt - a0, 1);

        a0 = ack_cnt;
        press(8'h3C, 10, lat);
        chk_int("3c_latency", lat, 7);
        chk_int("3c_acks", ack_cnt - a0, 1);

        cnt = 0;
        repeat (32) begin
            tick();
            if (dp_a === 1'b0) cnt++;
        end
        chk_int("dp_cycles", cnt, 6);

        // Asynchronous reset in the middle of digit 2's drive phase.
        n = 0;
        while (!(((k_m / SD) % 4) == 2 && (k_m % SD) == 4) && n < 64) begin
            tick();
            n++;
        end
        chk_int("reach_dig2_drive", {28'd0, sel_a}, 32'd11);
        #2 rst_n = 1'b0;
        #1 chk_reset_now("mid_rst");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();

        // Bounce then steady low: a single capture, none while held.
        ch = 8'($urandom);
        repeat (4) tick();
        a0 = ack_cnt;
        for (int i = 0; i < 20; i++) begin
            btn_load_n = (i % 2 == 1);
            tick();
        end
        btn_load_n = 1'b0;
        repeat (100) tick();
        chk_int("bounce_acks", ack_cnt - a0, 1);
        btn_load_n = 1'b1;
        repeat (15) tick();

        // Randomized bouncy presses.
        repeat (8) begin
            ch = 8'($urandom);
            repeat ($urandom_range(3, 8)) tick();
            repeat ($urandom_range(0, 5)) begin
                btn_load_n = ~btn_load_n;
                repeat ($urandom_range(1, 3)) tick();
            end
            btn_load_n = 1'b0;
            repeat ($urandom_range(5, 20)) tick();
            repeat ($urandom_range(0, 4)) begin
                btn_load_n = ~btn_load_n;
                repeat ($urandom_range(1, 3)) tick();
            end
            btn_load_n = 1'b1;
            repeat ($urandom_range(6, 20)) tick();
        end

        // No leading-zero suppression: every digit of 00F0 gets its drive window.
        do_reset();
        a0 = ack_cnt;
        press(8'hF0, 10, lat);
        chk_int("f0_acks", ack_cnt - a0, 1);
        cnt = 0;
        repeat (32) begin
            tick();
            if (sel_b !== 4'hF) cnt++;
        end
        chk_int("nolz_drive_cycles", cnt, 24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
